// File: rtl/fib_stream_ctrl.sv
// Stream-side driver/collector for the fib core: accepts n, pulses go, captures the result and presents it downstream.
// Optional watchdog on the go->done interval is enabled by defining FIB_TIMEOUT_EN.
module fib_stream_ctrl #(
    parameter int INPUT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_n,
    output logic                    fib_go,
    output logic [INPUT_WIDTH-1:0]  fib_n,
    input  logic [OUTPUT_WIDTH-1:0] fib_result,
    input  logic                    fib_overflow,
    input  logic                    fib_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_result,
    output logic                    out_overflow,
    output logic                    out_timeout,
    output logic [15:0]             jobs_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GO        = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   capture;
    logic   handshake;
    logic   tmo;
    logic   waiting;

    assign accept    = in_valid && in_ready;
    assign capture   = (state == WAIT_DONE) && fib_done;
    assign handshake = (state == HOLD) && out_valid && out_ready;
    assign waiting   = (state == WAIT_CLR) || (state == WAIT_DONE);

`ifdef FIB_TIMEOUT_EN
    logic [15:0] wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == GO) begin
            wdog <= '0;
        end else if (waiting) begin
            wdog <= wdog + 16'd1;
        end
    end

    // Fires on the wait cycle whose increment would reach the limit; a done in that cycle wins.
    assign tmo = waiting && !capture && (wdog == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept) state_nxt = GO;
            GO:        state_nxt = WAIT_CLR;
            WAIT_CLR:  if (tmo) state_nxt = HOLD;
                       else if (!fib_done) state_nxt = WAIT_DONE;
            WAIT_DONE: if (capture || tmo) state_nxt = HOLD;
            HOLD:      if (handshake) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && !rst;
        fib_go   = (state == GO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fib_n        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b0;
            jobs_done    <= '0;
        end else begin
            if (accept) fib_n <= in_n;
            if (capture) begin
                out_result   <= fib_result;
                out_overflow <= fib_overflow;
                out_timeout  <= 1'b0;
                out_valid    <= 1'b1;
            end else if (tmo) begin
                out_result   <= '0;
                out_overflow <= 1'b0;
                out_timeout  <= 1'b1;
                out_valid    <= 1'b1;
            end else if (handshake) begin
                out_valid   <= 1'b0;
                out_timeout <= 1'b0;
                jobs_done   <= jobs_done + 16'd1;
            end
        end
    end

endmodule
